// File: rtl/player_executor_if.sv
// Instruction/status bundle between the game state machine, the player executor and the renderer.
// startDmg qualifies an HPY/DPY word for exactly one cycle; hpAck answers it one cycle later and there is no backpressure.
interface player_executor_if;
    logic [15:0] playerInstruction;
    logic        isMove;
    logic        startDmg;
    logic [7:0]  playerHP;
    logic [9:0]  posX;
    logic [9:0]  posY;
    logic        isDeath;
    logic        hpAck;
    logic        invuln;
    logic [1:0]  state_dbg;

    modport master (
        output playerInstruction, isMove, startDmg,
        input  playerHP, posX, posY, isDeath, hpAck, invuln, state_dbg
    );

    modport slave (
        input  playerInstruction, isMove, startDmg,
        output playerHP, posX, posY, isDeath, hpAck, invuln, state_dbg
    );
endinterface

// File: rtl/player_executor.sv
// Executes HP/movement instructions; owns player HP and soul position inside the dodge box.
// Optional invulnerability frames after damage are built when INVULN_EN is defined.
module player_executor #(
    parameter int HP_MAX        = 100,
    parameter int BOX_X0        = 220,
    parameter int BOX_X1        = 420,
    parameter int BOX_Y0        = 240,
    parameter int BOX_Y1        = 400,
    parameter int PLAYER_SIZE   = 16,
    parameter int MOVE_STEP     = 2,
    parameter int MOVE_DIV      = 500000,
    parameter int IFRAME_CYCLES = 50000000
) (
    input logic              clk,
    input logic              reset,
    player_executor_if.slave pif
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ALIVE = 2'd1, S_DEAD = 2'd2} state_t;

    localparam logic [3:0] OP_HPY = 4'd1;
    localparam logic [3:0] OP_DPY = 4'd2;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_SHP = 4'd6;

    localparam logic [7:0] HP_TOP = 8'(HP_MAX);
    localparam logic [9:0] X_MIN  = 10'(BOX_X0);
    localparam logic [9:0] X_MAX  = 10'(BOX_X1 - PLAYER_SIZE);
    localparam logic [9:0] Y_MIN  = 10'(BOX_Y0);
    localparam logic [9:0] Y_MAX  = 10'(BOX_Y1 - PLAYER_SIZE);
    localparam logic [9:0] X_CTR  = 10'((BOX_X0 + BOX_X1 - PLAYER_SIZE) / 2);
    localparam logic [9:0] Y_CTR  = 10'((BOX_Y0 + BOX_Y1 - PLAYER_SIZE) / 2);
    localparam logic [9:0] STEP   = 10'(MOVE_STEP);

    localparam int              MV_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [MV_W-1:0] MV_LAST = MV_W'(MOVE_DIV - 1);

    state_t          state, state_n;
    logic [7:0]      hp, hp_n;
    logic [9:0]      pos_x, pos_x_n, pos_y, pos_y_n;
    logic [3:0]      prev_op;
    logic            ack_q, ack_n;
    logic            death_q;
    logic [MV_W-1:0] mv_cnt, mv_cnt_n;
    logic [8:0]      hp_sum;
    logic            dpy_blocked;

    wire [3:0] opcode   = pif.playerInstruction[15:12];
    wire [7:0] operand  = pif.playerInstruction[11:4];
    wire       shp_edge = (opcode == OP_SHP) && (prev_op != OP_SHP);

    logic unused_bits;
    assign unused_bits = ^pif.playerInstruction[3:0];

`ifdef INVULN_EN
    localparam int              IF_W    = $clog2(IFRAME_CYCLES + 1);
    localparam logic [IF_W-1:0] IF_LOAD = IF_W'(IFRAME_CYCLES);
    logic [IF_W-1:0] ifr_cnt, ifr_n;
    logic            inv_q;
    assign dpy_blocked = inv_q;
`else
    logic unused_iframe;
    assign unused_iframe = (IFRAME_CYCLES != 0);
    assign dpy_blocked   = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        hp_n     = hp;
        pos_x_n  = pos_x;
        pos_y_n  = pos_y;
        ack_n    = 1'b0;
        mv_cnt_n = '0;
        hp_sum   = {1'b0, hp} + {1'b0, operand};
`ifdef INVULN_EN
        ifr_n    = (ifr_cnt != '0) ? ifr_cnt - 1'b1 : '0;
`endif
        if (shp_edge) begin
            state_n = S_ALIVE;
            hp_n    = (operand != 8'd0 && operand <= HP_TOP) ? operand : HP_TOP;
            pos_x_n = X_CTR;
            pos_y_n = Y_CTR;
`ifdef INVULN_EN
            ifr_n   = '0;
`endif
        end else if (state == S_ALIVE) begin
            if (pif.startDmg && opcode == OP_HPY) begin
                ack_n = 1'b1;
                hp_n  = (hp_sum > {1'b0, HP_TOP}) ? HP_TOP : hp_sum[7:0];
            end
            if (pif.startDmg && opcode == OP_DPY) begin
                ack_n = 1'b1;
                // A zero-damage DPY is acknowledged but must never kill or start a window.
                if (operand != 8'd0 && !dpy_blocked) begin
                    if (operand >= hp) begin
                        hp_n    = 8'd0;
                        state_n = S_DEAD;
`ifdef INVULN_EN
                        ifr_n   = '0;
`endif
                    end else begin
                        hp_n  = hp - operand;
`ifdef INVULN_EN
                        ifr_n = IF_LOAD;
`endif
                    end
                end
            end
            if (pif.isMove && opcode == OP_MOV) begin
                mv_cnt_n = (mv_cnt == MV_LAST) ? '0 : mv_cnt + 1'b1;
                if (mv_cnt == '0) begin
                    case (operand)
                        8'd0: pos_y_n = (pos_y < Y_MIN + STEP) ? Y_MIN : pos_y - STEP;
                        8'd1: pos_x_n = (pos_x < X_MIN + STEP) ? X_MIN : pos_x - STEP;
                        8'd2: pos_y_n = (pos_y > Y_MAX - STEP) ? Y_MAX : pos_y + STEP;
                        8'd3: pos_x_n = (pos_x > X_MAX - STEP) ? X_MAX : pos_x + STEP;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            hp      <= 8'd0;
            pos_x   <= X_CTR;
            pos_y   <= Y_CTR;
            prev_op <= 4'd0;
            ack_q   <= 1'b0;
            death_q <= 1'b0;
            mv_cnt  <= '0;
`ifdef INVULN_EN
            ifr_cnt <= '0;
            inv_q   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            hp      <= hp_n;
            pos_x   <= pos_x_n;
            pos_y   <= pos_y_n;
            prev_op <= opcode;
            ack_q   <= ack_n;
            death_q <= (state_n == S_DEAD);
            mv_cnt  <= mv_cnt_n;
`ifdef INVULN_EN
            ifr_cnt <= ifr_n;
            inv_q   <= (ifr_n != '0);
`endif
        end
    end

    assign pif.playerHP  = hp;
    assign pif.posX      = pos_x;
    assign pif.posY      = pos_y;
    assign pif.isDeath   = death_q;
    assign pif.hpAck     = ack_q;
    assign pif.state_dbg = state;
`ifdef INVULN_EN
    assign pif.invuln    = inv_q;
`else
    assign pif.invuln    = 1'b0;
`endif
endmodule
